// File: rtl/display_scheduler.sv
// Round-robin display arbiter: four requesters compete for one seven-segment display,
// each grant owns the display for DWELL cycles (stretched by hold), with live view while requesting.
module display_scheduler #(
  parameter logic [26:0] DWELL = 27'd50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic        hold,
  output logic [3:0]  ack,
  output logic [1:0]  owner,
  output logic [31:0] disp_value,
  output logic        disp_valid
);

  // state  | meaning
  // S_IDLE | waiting for a request; display keeps its last value
  // S_LOAD | one-cycle grant, ack[g] asserted
  // S_SHOW | owner holds the display for DWELL unheld cycles
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  localparam logic [26:0] DWELL_LAST = DWELL - 27'd1;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_grant;
  logic [1:0]  r_last_owner;
  logic [1:0]  r_owner;
  logic [31:0] r_disp_value;
  logic        r_disp_valid;
  logic [26:0] r_cnt;

  logic [1:0]  w_pick;
  logic [1:0]  w_idx;
  logic        w_dwell_done;
  logic [31:0] w_data_grant;
  logic [31:0] w_data_owner;

  // Scan from farthest to nearest offset so the nearest requester after last_owner wins.
  always_comb begin
    w_pick = r_last_owner + 2'd1;
    w_idx  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last_owner + 2'(k);
      if (req[w_idx]) w_pick = w_idx;
    end
  end

  always_comb begin
    case (r_grant)
      2'd0:    w_data_grant = data0;
      2'd1:    w_data_grant = data1;
      2'd2:    w_data_grant = data2;
      default: w_data_grant = data3;
    endcase
  end

  always_comb begin
    case (r_owner)
      2'd0:    w_data_owner = data0;
      2'd1:    w_data_owner = data1;
      2'd2:    w_data_owner = data2;
      default: w_data_owner = data3;
    endcase
  end

  assign w_dwell_done = (r_cnt == DWELL_LAST);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ack    = 4'b0000;
    case (r_state)
      S_IDLE: if (!hold && (req != 4'b0000)) w_next = S_LOAD;
      S_LOAD: begin
        w_next       = S_SHOW;
        ack[r_grant] = 1'b1;
      end
      S_SHOW: if (!hold && w_dwell_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant      <= 2'd0;
      r_last_owner <= 2'd3;
      r_owner      <= 2'd0;
      r_disp_value <= 32'd0;
      r_disp_valid <= 1'b0;
      r_cnt        <= 27'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!hold && (req != 4'b0000)) r_grant <= w_pick;
        end
        S_LOAD: begin
          r_disp_value <= w_data_grant;
          r_owner      <= r_grant;
          r_last_owner <= r_grant;
          r_disp_valid <= 1'b1;
          r_cnt        <= 27'd0;
        end
        S_SHOW: begin
          if (req[r_owner]) r_disp_value <= w_data_owner;
          // Counter stops at DWELL-1; the FSM leaves SHOW on that same edge.
          if (!hold && !w_dwell_done) r_cnt <= r_cnt + 27'd1;
        end
        default: ;
      endcase
    end
  end

  assign owner      = r_owner;
  assign disp_value = r_disp_value;
  assign disp_valid = r_disp_valid;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with DWELL=4 (grant period DWELL+2 = 6 cycles).
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data0, data1, data2, data3;
  logic        hold;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic [31:0] disp_value;
  logic        disp_valid;

  int n_cmp = 0;
  int n_bad = 0;

  display_scheduler #(.DWELL(27'd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .hold       (hold),
    .ack        (ack),
    .owner      (owner),
    .disp_value (disp_value),
    .disp_valid (disp_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until ack is nonzero (bounded); n is the number of edges taken.
  task automatic wait_ack(output int n, output logic [3:0] a);
    n = 0;
    a = 4'b0000;
    while (a == 4'b0000 && n < 40) begin
      tick();
      n++;
      a = ack;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0000;
    hold  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    data0 = 32'h0; data1 = 32'h0; data2 = 32'h0; data3 = 32'h0;
    do_reset();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    n_cmp++; if (disp_value !== 32'h0) begin n_bad++; $display("FAIL reset_disp got=%h exp=0", disp_value); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", disp_valid); end
  endtask

  task automatic test_single();
    int n;
    logic [3:0] a;
    do_reset();
    data0 = 32'h12345678;
    req   = 4'b0001;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack got=%b exp=0001", ack); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_in_load got=%b exp=0", disp_valid); end
    tick();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_one_cycle got=%b exp=0000", ack); end
    n_cmp++; if (disp_value !== 32'h12345678) begin n_bad++; $display("FAIL single_disp got=%h exp=12345678", disp_value); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL single_owner got=%0d exp=0", owner); end
    n_cmp++; if (disp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", disp_valid); end
    // 4 SHOW edges + 1 IDLE edge before the next LOAD
    wait_ack(n, a);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL single_show_len got=%0d exp=5", n); end
    n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL single_regrant got=%b exp=0001", a); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    int n;
    logic [3:0] a;
    logic [3:0] exp_ack [5];
    logic [1:0] exp_own [5];
    logic [31:0] exp_dat [5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    data0 = 32'hD0D0D0D0; data1 = 32'hD1D1D1D1; data2 = 32'hD2D2D2D2; data3 = 32'hD3D3D3D3;
    exp_dat = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3, 32'hD0D0D0D0};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(n, a);
      n_cmp++; if (n !== ((i == 0) ? 1 : 5)) begin n_bad++; $display("FAIL rot_spacing[%0d] got=%0d exp=%0d", i, n, (i == 0) ? 1 : 5); end
      n_cmp++; if (a !== exp_ack[i]) begin n_bad++; $display("FAIL rot_ack[%0d] got=%b exp=%b", i, a, exp_ack[i]); end
      tick();
      n_cmp++; if (owner !== exp_own[i]) begin n_bad++; $display("FAIL rot_owner[%0d] got=%0d exp=%0d", i, owner, exp_own[i]); end
      n_cmp++; if (disp_value !== exp_dat[i]) begin n_bad++; $display("FAIL rot_disp[%0d] got=%h exp=%h", i, disp_value, exp_dat[i]); end
    end
    req = 4'b0000;
  endtask

  task automatic test_hold();
    int n;
    logic [3:0] a;
    do_reset();
    data1 = 32'h11110000;
    req   = 4'b0010;
    tick();
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL hold_grant got=%b exp=0010", ack); end
    req = 4'b0000;
    tick();
    n_cmp++; if (owner !== 2'd1) begin n_bad++; $display("FAIL hold_owner got=%0d exp=1", owner); end
    hold = 1'b1;
    req  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL hold_ack[%0d] got=%b exp=0000", i, ack); end
    end
    hold = 1'b0;
    // 4 unheld SHOW edges + 1 IDLE edge
    wait_ack(n, a);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL hold_show_len got=%0d exp=5", n); end
    n_cmp++; if (a !== 4'b0010) begin n_bad++; $display("FAIL hold_regrant got=%b exp=0010", a); end
    // hold in IDLE blocks arbitration
    do_reset();
    hold = 1'b1;
    req  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL hold_idle_ack[%0d] got=%b exp=0000", i, ack); end
    end
    hold = 1'b0;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL hold_idle_release got=%b exp=0001", ack); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_live();
    do_reset();
    data2 = 32'hA0000001;
    req   = 4'b0100;
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL live_grant got=%b exp=0100", ack); end
    tick();
    n_cmp++; if (disp_value !== 32'hA0000001) begin n_bad++; $display("FAIL live_step1 got=%h exp=a0000001", disp_value); end
    data2 = 32'hA0000002;
    tick();
    n_cmp++; if (disp_value !== 32'hA0000002) begin n_bad++; $display("FAIL live_step2 got=%h exp=a0000002", disp_value); end
    req   = 4'b0000;
    data2 = 32'hFFFFFFFF;
    tick();
    n_cmp++; if (disp_value !== 32'hA0000002) begin n_bad++; $display("FAIL live_freeze got=%h exp=a0000002", disp_value); end
    tick();
    tick();
    n_cmp++; if (disp_value !== 32'hA0000002) begin n_bad++; $display("FAIL live_idle_keep got=%h exp=a0000002", disp_value); end
    n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL live_idle_owner got=%0d exp=2", owner); end
    n_cmp++; if (disp_valid !== 1'b1) begin n_bad++; $display("FAIL live_idle_valid got=%b exp=1", disp_valid); end
    data0 = 32'h0BADF00D;
    req   = 4'b0001;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL live_next_grant got=%b exp=0001", ack); end
    n_cmp++; if (disp_value !== 32'hA0000002) begin n_bad++; $display("FAIL live_load_keep got=%h exp=a0000002", disp_value); end
    req = 4'b0000;
    tick();
    n_cmp++; if (disp_value !== 32'h0BADF00D) begin n_bad++; $display("FAIL live_next_disp got=%h exp=0badf00d", disp_value); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL live_next_owner got=%0d exp=0", owner); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data3 = 32'h33333333;
    req   = 4'b1000;
    tick();
    n_cmp++; if (ack !== 4'b1000) begin n_bad++; $display("FAIL rmid_grant got=%b exp=1000", ack); end
    tick();
    n_cmp++; if (owner !== 2'd3) begin n_bad++; $display("FAIL rmid_owner got=%0d exp=3", owner); end
    tick();
    reset = 1'b0;
    hold  = 1'b1;
    tick();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rmid_ack got=%b exp=0000", ack); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL rmid_owner0 got=%0d exp=0", owner); end
    n_cmp++; if (disp_value !== 32'h0) begin n_bad++; $display("FAIL rmid_disp got=%h exp=0", disp_value); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b exp=0", disp_valid); end
    reset = 1'b1;
    hold  = 1'b0;
    req   = 4'b0100;
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL rmid_regrant got=%b exp=0100", ack); end
    req = 4'b0000;
    tick();
    // reset during LOAD
    req = 4'b0001;
    do_reset();
    req = 4'b0001;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL rload_pre got=%b exp=0001", ack); end
    reset = 1'b0;
    tick();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rload_ack got=%b exp=0000", ack); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL rload_valid got=%b exp=0", disp_valid); end
    reset = 1'b1;
    req   = 4'b0000;
    tick();
  endtask

  task automatic test_regrant();
    int n;
    logic [3:0] a;
    do_reset();
    data3 = 32'h3C3C3C3C;
    req   = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, a);
      n_cmp++; if (n !== ((i == 0) ? 1 : 6)) begin n_bad++; $display("FAIL regrant_spacing[%0d] got=%0d exp=%0d", i, n, (i == 0) ? 1 : 6); end
      n_cmp++; if (a !== 4'b1000) begin n_bad++; $display("FAIL regrant_ack[%0d] got=%b exp=1000", i, a); end
    end
    tick();
    n_cmp++; if (owner !== 2'd3) begin n_bad++; $display("FAIL regrant_owner got=%0d exp=3", owner); end
    n_cmp++; if (disp_value !== 32'h3C3C3C3C) begin n_bad++; $display("FAIL regrant_disp got=%h exp=3c3c3c3c", disp_value); end
    req = 4'b0000;
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    hold  = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_hold();
    test_live();
    test_reset_mid();
    test_regrant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter: DWELL, 27'd50_000_000, number of clk cycles one grant owns the display; legal range 1..2^27-1.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset is synchronous and active-low.
REQ-004 req  input  4  req[i]=1: requester i asks to show its value.
REQ-005 data0, data1, data2, data3  input  32 each  requester values.
REQ-006 hold  input  1  freezes arbitration and the dwell count while 1.
REQ-007 ack  output  4  one-hot, one-cycle grant acknowledge.
REQ-008 owner  output  2  index of the current display owner.
REQ-009 disp_value  output  32  value driven to the 8-digit seven-segment driver.
REQ-010 disp_valid  output  1  1 once any value has been loaded since reset.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, LOAD, SHOW.
REQ-012 IDLE, hold=0, req!=0: the block SHALL select grant g round-robin, searching from (last_owner+1) mod 4 upward with wrap-around, and enter LOAD.
REQ-013 IDLE with req=0 or hold=1: the block SHALL stay in IDLE with all outputs unchanged except ack=0.
REQ-014 LOAD: the block SHALL last exactly one cycle, drive ack[g]=1 (all other ack bits 0), and enter SHOW.
REQ-015 On the edge leaving LOAD, the block SHALL set disp_value=data[g], owner=g, last_owner=g, disp_valid=1, and dwell counter=0.
REQ-016 The value of req in LOAD SHALL NOT affect the grant.
REQ-017 SHOW: the dwell counter SHALL increment by 1 per cycle when hold=0 and hold its value when hold=1.
REQ-018 SHOW: the FSM SHALL go to IDLE on the edge where counter==DWELL-1 and hold=0.
REQ-019 SHOW therefore SHALL last exactly DWELL cycles plus the number of hold-high cycles.
REQ-020 SHOW with req[owner]=1: disp_value SHALL be reloaded from data[owner] every cycle (live view).
REQ-021 SHOW with req[owner]=0: disp_value SHALL be frozen.
REQ-022 In IDLE, disp_value, owner and disp_valid SHALL retain their last values (the display never blanks after the first load).
REQ-023 Latency: req sampled in IDLE at edge k SHALL give ack during cycle k..k+1 and the new disp_value after edge k+1.
REQ-024 Continuous requests from several requesters SHALL be granted once per DWELL+2 cycles in strict rotation; no requester is starved.
REQ-025 If only the previous owner requests at re-arbitration, the block SHALL re-grant it.
REQ-026 Requests from other requesters during SHOW SHALL be ignored; there is no preemption.
REQ-027 ack SHALL be 0 in every state except LOAD.
REQ-028 ack SHALL never have more than one bit set.
REQ-029 The dwell counter SHALL be 27 bits, SHALL never exceed DWELL-1, and SHALL NOT wrap.

Reset
REQ-030 When reset=0 at a rising edge, the block SHALL set state=IDLE, disp_value=0, disp_valid=0, owner=0, ack=0, counter=0, last_owner=3 (so requester 0 has first priority).
REQ-031 Reset SHALL apply from any state, including mid-LOAD and mid-SHOW, and SHALL take priority over hold and req.
REQ-032 In the first cycle after reset is released, the block SHALL behave as IDLE.

Verification (DWELL=4 for simulation)
REQ-033 Reset, then req=0001, data0=0x12345678 -> ack=0001 for one cycle; then disp_value=0x12345678, owner=0, disp_valid=1; SHOW lasts 4 cycles; then IDLE.
REQ-034 req=1111 held high -> ack sequence 0001, 0010, 0100, 1000, 0001 with a 6-cycle spacing; owner follows 0,1,2,3,0.
REQ-035 Grant to requester 1, then hold=1 for 3 cycles inside SHOW -> SHOW lasts 7 cycles; ack=0 throughout.
REQ-036 Owner 2 is live with data2 stepping 0xA0000001, 0xA0000002; req[2] drops, then data2=0xFFFFFFFF -> disp_value tracks the steps, then stays 0xA0000002 until the next grant.
REQ-037 reset=0 for one edge during SHOW of owner 3 -> outputs equal REQ-030 values on the next cycle; then req=0100 -> granted 2, and requester 0 is not favoured.
REQ-038 req=1000 only, after last_owner=3 -> requester 3 is re-granted on every arbitration.
